// File: rtl/game_pkg.sv
// Shared game-bus definitions: state codes, display glyph codes and helpers.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package game_pkg;

  // Game state codes driven by the state controller. Codes 2 and 7 are undefined.
  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_SETTING   = 3'd1;
  localparam logic [2:0] ST_COUNTDOWN = 3'd3;
  localparam logic [2:0] ST_RACING    = 3'd4;
  localparam logic [2:0] ST_PAUSE     = 3'd5;
  localparam logic [2:0] ST_FINISH    = 3'd6;

  // Default clk cycles per second (100 MHz board clock).
  localparam int unsigned SECOND_DEFAULT = 100_000_000;

  // Largest value the 4-digit display can show.
  localparam logic [13:0] SEC_MAX = 14'd9999;

  // Glyph codes: the numeric glyphs are deliberately 0..9 so a BCD nibble
  // maps onto its glyph by a plain cast.
  typedef enum logic [4:0] {
    GL_0, GL_1, GL_2, GL_3, GL_4, GL_5, GL_6, GL_7, GL_8, GL_9,
    GL_BLANK, GL_DASH, GL_S, GL_T, GL_E, GL_G, GL_O
  } glyph_t;

  function automatic logic is_illegal_state(input logic [2:0] s);
    return (s == 3'd2) || (s == 3'd7);
  endfunction

  function automatic glyph_t digit_glyph(input logic [3:0] bcd);
    return glyph_t'({1'b0, bcd});
  endfunction

  // Shift-and-add-3 conversion of a 14-bit value (0..9999) to four BCD digits.
  function automatic logic [15:0] bin_to_bcd(input logic [13:0] bin);
    logic [29:0] sh;
    sh = {16'd0, bin};
    for (int i = 0; i < 14; i++) begin
      for (int k = 0; k < 4; k++) begin
        if (sh[14 + 4*k +: 4] >= 4'd5) begin
          sh[14 + 4*k +: 4] = sh[14 + 4*k +: 4] + 4'd3;
        end
      end
      sh = sh << 1;
    end
    return sh[29:14];
  endfunction

endpackage

// File: rtl/seg7_glyph.sv
// Glyph code to 7-segment pattern lookup, shared by the display blocks.
// Latency: combinational.
// Backpressure: none.
//   glyph : glyph code (game_pkg::glyph_t)
//   seg_n : segments {g,f,e,d,c,b,a}, active-low (seg_n[0] = a)
module seg7_glyph
  import game_pkg::*;
(
  input  glyph_t     glyph,
  output logic [6:0] seg_n
);

  logic [6:0] lit;

  always_comb begin
    lit = 7'h00;
    case (glyph)
      GL_0:     lit = 7'h3F;
      GL_1:     lit = 7'h06;
      GL_2:     lit = 7'h5B;
      GL_3:     lit = 7'h4F;
      GL_4:     lit = 7'h66;
      GL_5:     lit = 7'h6D;
      GL_6:     lit = 7'h7D;
      GL_7:     lit = 7'h07;
      GL_8:     lit = 7'h7F;
      GL_9:     lit = 7'h6F;
      GL_DASH:  lit = 7'h40;
      GL_S:     lit = 7'h6D;
      GL_T:     lit = 7'h78;
      GL_E:     lit = 7'h79;
      GL_G:     lit = 7'h3D;
      GL_O:     lit = 7'h5C;
      default:  lit = 7'h00;
    endcase
    seg_n = ~lit;
  end

endmodule

// File: rtl/race_state_decoder.sv
// Game-state consumer: 4-digit muxed 7-seg display, race seconds timer, start/end pulses.
// Latency: 1 clk from state / countdown_val / race_seconds / scan counter to seg, an, dp.
// Backpressure: none; free-running, every output updates every cycle.
//   clk, rst         : clock, synchronous active-high reset
//   state            : game state code (3 bits), countdown_val: countdown digit 3..0
//   seg, an, dp      : active-low segments a..g, digit anodes (an[0] rightmost), decimal point
//   race_seconds     : elapsed race seconds 0..9999
//   race_start/end   : one-cycle pulses on COUNTDOWN->RACING / RACING->FINISH
//   illegal_state    : state held an undefined code on the previous cycle
module race_state_decoder
  import game_pkg::*;
#(
  parameter int unsigned SECOND     = SECOND_DEFAULT,
  parameter int unsigned SCAN_BITS  = 18,
  parameter int unsigned BLINK_HALF = 50_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  state,
  input  logic [1:0]  countdown_val,
  output logic [6:0]  seg,
  output logic [3:0]  an,
  output logic        dp,
  output logic [13:0] race_seconds,
  output logic        race_start,
  output logic        race_end,
  output logic        illegal_state
);

  localparam int unsigned SUB_W   = (SECOND > 1) ? $clog2(SECOND) : 1;
  localparam int unsigned BLINK_W = $clog2(2 * BLINK_HALF);

  localparam logic [SUB_W-1:0]   SUB_LAST   = SUB_W'(SECOND - 1);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(2 * BLINK_HALF - 1);
  localparam logic [BLINK_W-1:0] BLINK_VIS  = BLINK_W'(BLINK_HALF);

  logic [SCAN_BITS-1:0] scan_cnt;
  logic [SUB_W-1:0]     sub_cnt, sub_nxt;
  logic [13:0]          sec_nxt;
  logic [BLINK_W-1:0]   blink_cnt, blink_nxt;
  logic [2:0]           prev_state;
  logic [15:0]          bcd_q;

  logic [1:0]  digit;
  logic [3:0]  cur_bcd;
  logic        blink_visible;
  glyph_t      glyph;
  logic [6:0]  glyph_seg_n;
  logic        dp_nxt;

  assign digit         = scan_cnt[SCAN_BITS-1 -: 2];
  assign cur_bcd       = bcd_q[{digit, 2'b00} +: 4];
  assign blink_visible = (blink_cnt < BLINK_VIS);

  // Race timer: counts only in RACING, cleared in IDLE/COUNTDOWN, held otherwise.
  always_comb begin
    sub_nxt = sub_cnt;
    sec_nxt = race_seconds;
    case (state)
      ST_RACING: begin
        if (sub_cnt == SUB_LAST) begin
          sub_nxt = '0;
          if (race_seconds != SEC_MAX) begin
            sec_nxt = race_seconds + 14'd1;
          end
        end else begin
          sub_nxt = sub_cnt + SUB_W'(1);
        end
      end
      ST_IDLE, ST_COUNTDOWN: begin
        sub_nxt = '0;
        sec_nxt = '0;
      end
      default: ;
    endcase
  end

  // Blink phase restarts from the visible half on every entry to PAUSE.
  always_comb begin
    blink_nxt = '0;
    if (state == ST_PAUSE) begin
      blink_nxt = (blink_cnt == BLINK_LAST) ? '0 : blink_cnt + BLINK_W'(1);
    end
  end

  // Glyph and decimal point for the digit currently being scanned.
  always_comb begin
    glyph  = GL_BLANK;
    dp_nxt = 1'b1;
    case (state)
      ST_IDLE: glyph = GL_DASH;
      ST_SETTING: begin
        case (digit)
          2'd3:    glyph = GL_S;
          2'd2:    glyph = GL_E;
          2'd1:    glyph = GL_T;
          default: glyph = GL_BLANK;
        endcase
      end
      ST_COUNTDOWN: begin
        if (countdown_val == 2'd0) begin
          if (digit == 2'd1)      glyph = GL_G;
          else if (digit == 2'd0) glyph = GL_O;
        end else if (digit == 2'd0) begin
          glyph = glyph_t'({3'b000, countdown_val});
        end
      end
      ST_RACING: glyph = digit_glyph(cur_bcd);
      ST_PAUSE:  glyph = blink_visible ? digit_glyph(cur_bcd) : GL_BLANK;
      ST_FINISH: begin
        glyph  = digit_glyph(cur_bcd);
        dp_nxt = (digit != 2'd0);
      end
      default: glyph = GL_E;
    endcase
  end

  seg7_glyph u_glyph (
    .glyph (glyph),
    .seg_n (glyph_seg_n)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      scan_cnt      <= '0;
      sub_cnt       <= '0;
      race_seconds  <= '0;
      blink_cnt     <= '0;
      prev_state    <= ST_IDLE;
      bcd_q         <= '0;
      seg           <= 7'h7F;
      an            <= 4'hF;
      dp            <= 1'b1;
      race_start    <= 1'b0;
      race_end      <= 1'b0;
      illegal_state <= 1'b0;
    end else begin
      scan_cnt      <= scan_cnt + SCAN_BITS'(1);
      sub_cnt       <= sub_nxt;
      race_seconds  <= sec_nxt;
      blink_cnt     <= blink_nxt;
      prev_state    <= state;
      // BCD tracks the next seconds value so the display sees the new
      // count in the same cycle race_seconds shows it, plus one register.
      bcd_q         <= bin_to_bcd(sec_nxt);
      seg           <= glyph_seg_n;
      an            <= ~(4'b0001 << digit);
      dp            <= dp_nxt;
      race_start    <= (prev_state == ST_COUNTDOWN) && (state == ST_RACING);
      race_end      <= (prev_state == ST_RACING) && (state == ST_FINISH);
      illegal_state <= is_illegal_state(state);
    end
  end

endmodule

// File: tb/tb_race_state_decoder.sv
// Bench for race_state_decoder: directed phases with randomized hold times,
// then a randomized state walk, all compared against a text-level display model.
module tb_race_state_decoder;

  localparam int SECOND     = 10;
  localparam int BLINK_HALF = 4;
  localparam int SCAN_BITS  = 4;

  logic        clk;
  logic        rst;
  logic [2:0]  state;
  logic [1:0]  countdown_val;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic        dp;
  logic [13:0] race_seconds;
  logic        race_start;
  logic        race_end;
  logic        illegal_state;

  race_state_decoder #(
    .SECOND     (SECOND),
    .SCAN_BITS  (SCAN_BITS),
    .BLINK_HALF (BLINK_HALF)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .state         (state),
    .countdown_val (countdown_val),
    .seg           (seg),
    .an            (an),
    .dp            (dp),
    .race_seconds  (race_seconds),
    .race_start    (race_start),
    .race_end      (race_end),
    .illegal_state (illegal_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model state, kept in plain integers.
  int m_scan  = 0;   // cycles since reset, modulo 2**SCAN_BITS
  int m_sub   = 0;   // cycles into the current race second
  int m_sec   = 0;   // race seconds
  int m_pause = 0;   // consecutive cycles already spent in PAUSE
  int m_prev  = 0;   // state seen on the previous cycle
  bit skip_disp = 0;
  int n_start = 0, n_end = 0, n_blank = 0;

  // Lit segments of a character, by segment letter.
  function automatic string char_segs(input byte c);
    case (c)
      "0": return "abcdef";
      "1": return "bc";
      "2": return "abdeg";
      "3": return "abcdg";
      "4": return "bcfg";
      "5": return "acdfg";
      "6": return "acdefg";
      "7": return "abc";
      "8": return "abcdefg";
      "9": return "abcdfg";
      "-": return "g";
      "S": return "acdfg";
      "t": return "defg";
      "E": return "adefg";
      "G": return "acdef";
      "o": return "cdeg";
      default: return "";
    endcase
  endfunction

  function automatic logic [6:0] lit(input string segs);
    logic [6:0] m;
    m = '0;
    for (int i = 0; i < segs.len(); i++) begin
      int idx;
      idx = int'(segs[i]) - 97;
      m[idx] = 1'b1;
    end
    return m;
  endfunction

  // Four characters the display should show, leftmost (digit3) first.
  function automatic string disp_text(input int s, input int cv, input int sec, input bit vis);
    case (s)
      0: return "----";
      1: return "SEt ";
      3: return (cv == 0) ? "  Go" : $sformatf("   %0d", cv);
      4, 6: return $sformatf("%04d", sec);
      5: return vis ? $sformatf("%04d", sec) : "    ";
      default: return "EEEE";
    endcase
  endfunction

  // One clock: predict post-edge outputs from pre-edge inputs, advance the
  // model, then compare 1 time unit after the edge.
  task automatic step();
    logic [6:0] e_seg;
    logic [3:0] e_an;
    logic       e_dp, e_st, e_en, e_ill;
    int         s, d;
    string      txt;
    bit         vis;
    s = int'(state);
    if (rst) begin
      e_seg = 7'h7F; e_an = 4'hF; e_dp = 1'b1;
      e_st = 1'b0; e_en = 1'b0; e_ill = 1'b0;
      m_scan = 0; m_sub = 0; m_sec = 0; m_pause = 0; m_prev = 0;
    end else begin
      d     = (m_scan / (1 << (SCAN_BITS - 2))) % 4;
      vis   = (m_pause % (2 * BLINK_HALF)) < BLINK_HALF;
      txt   = disp_text(s, int'(countdown_val), m_sec, vis);
      e_seg = ~lit(char_segs(txt[3 - d]));
      e_an  = 4'hF ^ (4'h1 << d);
      e_dp  = !(s == 6 && d == 0);
      e_st  = (m_prev == 3 && s == 4);
      e_en  = (m_prev == 4 && s == 6);
      e_ill = (s == 2 || s == 7);
      if (s == 4) begin
        if (m_sub == SECOND - 1) begin
          m_sub = 0;
          if (m_sec < 9999) m_sec++;
        end else begin
          m_sub++;
        end
      end else if (s == 0 || s == 3) begin
        m_sub = 0;
        m_sec = 0;
      end
      m_pause = (s == 5) ? m_pause + 1 : 0;
      m_prev  = s;
      m_scan  = (m_scan + 1) % (1 << SCAN_BITS);
    end
    @(posedge clk);
    #1;
    if (!skip_disp) chk("seg", 32'(seg), 32'(e_seg));
    skip_disp = 0;
    chk("an", 32'(an), 32'(e_an));
    chk("dp", 32'(dp), 32'(e_dp));
    chk("race_seconds", 32'(race_seconds), 32'(m_sec));
    chk("race_start", 32'(race_start), 32'(e_st));
    chk("race_end", 32'(race_end), 32'(e_en));
    chk("illegal_state", 32'(illegal_state), 32'(e_ill));
    if (race_start === 1'b1) n_start++;
    if (race_end === 1'b1) n_end++;
    if (seg === 7'h7F) n_blank++;
  endtask

  initial begin
    rst = 1'b1;
    state = 3'd0;
    countdown_val = 2'd0;
    step();
    step();
    chk("reset_seg", 32'(seg), 32'h7F);
    chk("reset_an", 32'(an), 32'hF);
    rst = 1'b0;

    // IDLE: dashes on every scanned digit.
    repeat (20) step();
    chk("idle_seconds", 32'(race_seconds), 32'd0);

    // SETTING then countdown 3,2,1,Go.
    state = 3'd1;
    repeat ($urandom_range(3, 8)) step();
    state = 3'd3;
    for (int v = 3; v >= 0; v--) begin
      countdown_val = 2'(v);
      repeat ($urandom_range(2, 6)) step();
    end
    chk("countdown_seconds", 32'(race_seconds), 32'd0);

    // Race start: exactly one pulse, 3 seconds after 35 cycles.
    n_start = 0;
    state = 3'd4;
    repeat (35) step();
    chk("race_35_seconds", 32'(race_seconds), 32'd3);
    chk("race_start_count", 32'(n_start), 32'd1);

    // New race: 25 racing, 20 paused, 10 racing.
    state = 3'd0;
    repeat ($urandom_range(2, 5)) step();
    state = 3'd3;
    countdown_val = 2'(($urandom_range(0, 3)));
    repeat ($urandom_range(2, 5)) step();
    state = 3'd4;
    repeat (25) step();
    chk("pre_pause_seconds", 32'(race_seconds), 32'd2);
    n_start = 0;
    n_blank = 0;
    state = 3'd5;
    repeat (20) step();
    chk("pause_seconds", 32'(race_seconds), 32'd2);
    chk("pause_blank_cycles", 32'(n_blank), 32'd8);
    state = 3'd4;
    repeat (10) step();
    chk("resume_seconds", 32'(race_seconds), 32'd3);
    chk("resume_no_start", 32'(n_start), 32'd0);

    // Saturation near 9999.
    force dut.race_seconds = 14'd9998;
    #2;
    release dut.race_seconds;
    m_sec = 9998;
    skip_disp = 1;
    repeat (30) step();
    chk("saturate_seconds", 32'(race_seconds), 32'd9999);
    n_end = 0;
    state = 3'd6;
    repeat (16) step();
    chk("race_end_count", 32'(n_end), 32'd1);
    chk("finish_seconds", 32'(race_seconds), 32'd9999);

    // PAUSE -> FINISH gives no end pulse.
    state = 3'd0;
    step();
    state = 3'd3;
    step();
    state = 3'd4;
    repeat (4) step();
    state = 3'd5;
    repeat (3) step();
    n_end = 0;
    state = 3'd6;
    repeat (4) step();
    chk("pause_finish_no_end", 32'(n_end), 32'd0);

    // Illegal codes.
    state = 3'd7;
    repeat (6) step();
    chk("illegal_7", 32'(illegal_state), 32'd1);
    state = 3'd2;
    repeat (3) step();

    // Reset in the middle of a race.
    state = 3'd3;
    step();
    state = 3'd4;
    repeat (15) step();
    rst = 1'b1;
    step();
    chk("midrace_rst_seconds", 32'(race_seconds), 32'd0);
    chk("midrace_rst_seg", 32'(seg), 32'h7F);
    chk("midrace_rst_an", 32'(an), 32'hF);
    rst = 1'b0;

    // Randomized state walk.
    for (int k = 0; k < 80; k++) begin
      state = 3'($urandom_range(0, 7));
      countdown_val = 2'($urandom_range(0, 3));
      rst = ($urandom_range(0, 24) == 0);
      step();
      rst = 1'b0;
      repeat ($urandom_range(0, 14)) step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/race_state_decoder.md
Name: race_state_decoder

Overview:
- Consumer side of the game state bus: takes the 3-bit `state` code and the 2-bit `countdown_val` from the state controller.
- Drives the board's 4-digit multiplexed 7-segment display.
- Keeps the race elapsed-seconds timer.
- Emits one-cycle race start/end event pulses for the gameplay and audio blocks.

Parameters:
- SECOND, 100_000_000, clk cycles per second (100 MHz clk).
- SCAN_BITS, 18, width of the digit-scan counter; digit index = top 2 bits.
- BLINK_HALF, 50_000_000, clk cycles per blink half-period in PAUSE.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- state  in  3  game state code
- countdown_val  in  2  countdown digit, 3..0
- seg  out  7  segments a..g, active-low, registered
- an  out  4  digit anodes, active-low one-hot, an[0] = rightmost digit, registered
- dp  out  1  decimal point, active-low, registered
- race_seconds  out  14  elapsed race seconds, binary, 0..9999
- race_start  out  1  one-cycle pulse on COUNTDOWN->RACING
- race_end  out  1  one-cycle pulse on RACING->FINISH
- illegal_state  out  1  high while `state` holds an undefined code

Behaviour:
- State codes: IDLE=0, SETTING=1, COUNTDOWN=3, RACING=4, PAUSE=5, FINISH=6. Codes 2 and 7 are illegal.
- Reset values:
  - seg=7'h7F, an=4'hF, dp=1 (display dark for one cycle)
  - race_seconds=0, race_start=0, race_end=0, illegal_state=0
  - prev_state=IDLE; all counters 0
- Scan:
  - Free-running SCAN_BITS counter; digit d = cnt[top:top-1]; an = ~(1<<d).
  - seg/an/dp are registered: 1-cycle latency from state/counter change to pins.
- Timer:
  - Sub-second counter 0..SECOND-1 and race_seconds advance only while state==RACING.
  - race_seconds increments when sub==SECOND-1, then sub wraps to 0.
  - Held in PAUSE and FINISH.
  - Cleared (sub and seconds) while state is IDLE or COUNTDOWN.
  - Unchanged in SETTING and in illegal codes.
  - Saturates at 9999: stays 9999, sub keeps wrapping.
- Binary-to-BCD: race_seconds is shown as 4 decimal digits, leading zeros shown. Conversion is combinational (or pipelined), but its output is registered before glyph lookup so total latency stays 1 cycle from race_seconds to seg.
- Display content per state (digit3..digit0):
  - IDLE: "----"
  - SETTING: "SEt " (digit0 blank)
  - COUNTDOWN: digits 3..1 blank; digit0 shows countdown_val as "3", "2" or "1"; countdown_val==0 shows "Go" on digits1..0.
  - RACING: BCD of race_seconds.
  - PAUSE: same digits as RACING, blinking.
  - FINISH: same digits as RACING, steady, dp on digit0 (dp=0 while d==0).
  - Illegal: "EEEE"; illegal_state=1.
- dp=1 in all other cases.
- Blink:
  - Counter 0..2*BLINK_HALF-1 runs only in PAUSE and is cleared on any cycle state!=PAUSE.
  - Digits are visible while counter < BLINK_HALF and blank (seg=7'h7F, an still scans) otherwise.
  - Entry to PAUSE therefore always starts with the visible phase.
- Events:
  - prev_state register is updated every cycle.
  - race_start=1 in the cycle after a cycle with prev_state==COUNTDOWN && state==RACING; it is registered, one cycle wide.
  - PAUSE->RACING resume does NOT pulse race_start.
  - race_end is defined the same way for RACING->FINISH.
  - PAUSE->FINISH is not a legal producer transition; no pulse.
- Reset mid-race: all timers, pulses and display return to reset values on the next edge; no event pulse is generated by reset.
- Input changes within a digit slot take effect at the next clk edge; no glitch-free requirement beyond registered outputs.

Decomposition:
- Shared package game_pkg:
  - state code localparams (IDLE..FINISH); the state controller is migrated to this same package.
  - glyph codes: 0-9, BLANK, DASH, S, t, E, G, o.
  - SECOND default.
- Sub-module seg7_glyph: combinational glyph code -> active-low a..g pattern, reusable by other display blocks.
- Timer and blink counters stay inline.

Test Plan (SECOND=10, BLINK_HALF=4, SCAN_BITS=4):
- Reset, then state=IDLE held -> after 1 cycle, every scanned digit shows the DASH pattern with an cycling 1110, 1101, 1011, 0111; race_seconds=0; no pulses.
- COUNTDOWN with countdown_val 3->2->1->0 -> digit0 shows 3, 2, 1, then digits1..0 show "Go"; digits3..2 blank; race_seconds stays 0.
- COUNTDOWN->RACING, hold 35 cycles -> race_start high for exactly one cycle, one cycle after the transition; race_seconds=3; display "0003".
- RACING 25 cycles, PAUSE 20 cycles, RACING 10 cycles -> race_seconds 2 (held through PAUSE) then 3; visible 4 cycles / blank 4 cycles while in PAUSE; no race_start on resume.
- Force race_seconds to 9998, run 30 cycles -> saturates at 9999; RACING->FINISH gives one race_end pulse; digit0 dp=0 in FINISH.
- state=7 -> "EEEE", illegal_state=1; rst asserted in RACING -> race_seconds=0, seg=7'h7F, an=4'hF next cycle.
